nxn_board_engine: RTL and testbench

NXN_BOARD_ENGINE -- requirements
Module: nxn_board_engine

---
 rtl/nxn_board_pkg.sv | 30 +++
 rtl/board_line_scan.sv | 65 ++++++
 rtl/nxn_board_engine.sv | 142 ++++++++++++++
 tb/tb_nxn_board_engine.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nxn_board_pkg.sv
// Shared codes for the NxN board engine: cell contents, winner codes and FSM state encoding.
package nxn_board_pkg;

    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    // SCAN0..EVAL are consecutive so the scan sequence can simply increment.
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_SCAN0 = 3'd1;
    localparam state_t ST_SCAN1 = 3'd2;
    localparam state_t ST_SCAN2 = 3'd3;
    localparam state_t ST_SCAN3 = 3'd4;
    localparam state_t ST_EVAL  = 3'd5;
    localparam state_t ST_DONE  = 3'd6;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_P1    = 2'b01;
    localparam logic [1:0] CELL_P2    = 2'b10;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    // Cell code and winner code of a player share the same encoding.
    function automatic logic [1:0] player_cell(input logic player);
        return player ? CELL_P2 : CELL_P1;
    endfunction

endpackage

// File: rtl/board_line_scan.sv
// Combinational count of contiguous same-player stones through one cell along one direction,
// both senses, clipped at the board edges and saturated at WIN_K.
module board_line_scan
    import nxn_board_pkg::*;
#(
    parameter int BOARD_N = 3,
    parameter int WIN_K   = 3,
    parameter int IDX_W   = $clog2(BOARD_N*BOARD_N)
) (
    input  logic [2*BOARD_N*BOARD_N-1:0] board,
    input  logic [IDX_W-1:0]             cell_idx,
    input  logic [1:0]                   dir,
    input  logic [1:0]                   player,
    output logic [3:0]                   line_count
);

    localparam int NN = BOARD_N*BOARD_N;
    localparam logic [3:0] SAT = 4'(WIN_K);

    logic [NN-1:0] mine;

    always_comb begin
        mine = '0;
        for (int k = 0; k < NN; k++) begin
            mine[k] = (board[2*k +: 2] == player);
        end
    end

    // Steps walk row/column coordinates, so a step off either edge ends the run instead of wrapping.
    always_comb begin
        int row, col, dr, dc, r, c;
        logic run, hit;
        line_count = 4'd1;
        row = int'(cell_idx) / BOARD_N;
        col = int'(cell_idx) % BOARD_N;
        dr  = 0;
        dc  = 1;
        r   = 0;
        c   = 0;
        run = 1'b1;
        hit = 1'b0;
        case (dir)
            2'd0:    begin dr = 0; dc = 1;  end
            2'd1:    begin dr = 1; dc = 0;  end
            2'd2:    begin dr = 1; dc = 1;  end
            default: begin dr = 1; dc = -1; end
        endcase
        for (int sense = 0; sense < 2; sense++) begin
            run = 1'b1;
            for (int s = 1; s < BOARD_N; s++) begin
                r   = (sense == 0) ? row + s*dr : row - s*dr;
                c   = (sense == 0) ? col + s*dc : col - s*dc;
                hit = 1'b0;
                if (r >= 0 && r < BOARD_N && c >= 0 && c < BOARD_N) begin
                    for (int k = 0; k < NN; k++) begin
                        if (k == r*BOARD_N + c) hit = mine[k];
                    end
                end
                if (!hit) run = 1'b0;
                if (run && line_count < SAT) line_count = line_count + 4'd1;
            end
        end
    end

endmodule

// File: rtl/nxn_board_engine.sv
// NxN k-in-a-row board engine: validates and places moves, then scans four directions
// through the placed stone before deciding win, draw or next turn.
module nxn_board_engine
    import nxn_board_pkg::*;
#(
    parameter int BOARD_N = 3,
    parameter int WIN_K   = 3,
    parameter int IDX_W   = $clog2(BOARD_N*BOARD_N)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         new_game,
    input  logic                         move_valid,
    input  logic                         move_player,
    input  logic [IDX_W-1:0]             move_idx,
    output logic                         move_ready,
    output logic                         move_ack,
    output logic                         illegal_move,
    output logic                         turn,
    output logic                         over,
    output logic [1:0]                   winner,
    output logic [2*BOARD_N*BOARD_N-1:0] board_flat
);

    localparam int NN    = BOARD_N*BOARD_N;
    localparam int CNT_W = $clog2(NN+1);
    localparam logic [IDX_W:0]   IDX_LIMIT = (IDX_W+1)'(NN);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(NN);
    localparam logic [3:0]       WIN_LEN   = 4'(WIN_K);

    state_t           state;
    logic [CNT_W-1:0] move_cnt;
    logic [IDX_W-1:0] last_idx;
    logic             last_player;
    logic             win_flag;
    logic [1:0]       scan_dir;
    logic [3:0]       line_count;
    logic             cell_busy;
    logic             move_legal;

    assign move_ready = (state == ST_IDLE);

    always_comb begin
        cell_busy = 1'b0;
        for (int k = 0; k < NN; k++) begin
            if (k == int'(move_idx) && board_flat[2*k +: 2] != CELL_EMPTY) cell_busy = 1'b1;
        end
        move_legal = ({1'b0, move_idx} < IDX_LIMIT) && !cell_busy && (move_player == turn);
    end

    always_comb begin
        case (state)
            ST_SCAN1: scan_dir = 2'd1;
            ST_SCAN2: scan_dir = 2'd2;
            ST_SCAN3: scan_dir = 2'd3;
            default:  scan_dir = 2'd0;
        endcase
    end

    board_line_scan #(
        .BOARD_N (BOARD_N),
        .WIN_K   (WIN_K),
        .IDX_W   (IDX_W)
    ) u_line_scan (
        .board      (board_flat),
        .cell_idx   (last_idx),
        .dir        (scan_dir),
        .player     (player_cell(last_player)),
        .line_count (line_count)
    );

    // new_game outranks everything but reset, including a move in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            board_flat   <= '0;
            turn         <= 1'b0;
            over         <= 1'b0;
            winner       <= WIN_NONE;
            move_ack     <= 1'b0;
            illegal_move <= 1'b0;
            move_cnt     <= '0;
            last_idx     <= '0;
            last_player  <= 1'b0;
            win_flag     <= 1'b0;
        end else begin
            move_ack     <= 1'b0;
            illegal_move <= 1'b0;
            if (new_game) begin
                state      <= ST_IDLE;
                board_flat <= '0;
                turn       <= 1'b0;
                over       <= 1'b0;
                winner     <= WIN_NONE;
                move_cnt   <= '0;
                win_flag   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (move_valid) begin
                            if (move_legal) begin
                                for (int k = 0; k < NN; k++) begin
                                    if (k == int'(move_idx)) board_flat[2*k +: 2] <= player_cell(move_player);
                                end
                                move_ack    <= 1'b1;
                                move_cnt    <= move_cnt + 1'b1;
                                last_idx    <= move_idx;
                                last_player <= move_player;
                                win_flag    <= 1'b0;
                                state       <= ST_SCAN0;
                            end else begin
                                illegal_move <= 1'b1;
                            end
                        end
                    end
                    ST_SCAN0, ST_SCAN1, ST_SCAN2, ST_SCAN3: begin
                        if (line_count >= WIN_LEN) win_flag <= 1'b1;
                        state <= state + 3'd1;
                    end
                    // A win is checked before the full-board test so the last free cell can still win.
                    ST_EVAL: begin
                        if (win_flag) begin
                            over   <= 1'b1;
                            winner <= player_cell(last_player);
                            state  <= ST_DONE;
                        end else if (move_cnt == CNT_FULL) begin
                            over   <= 1'b1;
                            winner <= WIN_DRAW;
                            state  <= ST_DONE;
                        end else begin
                            turn  <= ~turn;
                            state <= ST_IDLE;
                        end
                    end
                    ST_DONE: state <= ST_DONE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nxn_board_engine.sv
// Scoreboard bench for nxn_board_engine: a 3x3/K=3 instance and a 5x5/K=4 instance share stimulus;
// a monitor pops expected events (ack, illegal, game over) as the selected DUT presents them.
module tb_nxn_board_engine;

    localparam int K_NONE = 0;
    localparam int K_ACK  = 1;
    localparam int K_ILL  = 2;
    localparam int K_OVER = 3;

    typedef struct {
        int         kind;
        logic [1:0] winner;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        new_game;
    logic        move_valid;
    logic        move_player;
    logic [3:0]  idx3;
    logic [4:0]  idx5;
    logic        sel;

    logic        ready3, ack3, ill3, turn3, over3;
    logic [1:0]  winner3;
    logic [17:0] board3;
    logic        ready5, ack5, ill5, turn5, over5;
    logic [1:0]  winner5;
    logic [49:0] board5;

    logic        ready_m, ack_m, ill_m, turn_m, over_m;
    logic [1:0]  winner_m;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cycle_cnt = 0;
    int   last_ack = 0;
    logic over_q = 1'b0;

    always #5 clk = ~clk;

    nxn_board_engine #(.BOARD_N(3), .WIN_K(3)) dut3 (
        .clk (clk), .reset_n (reset_n), .new_game (new_game), .move_valid (move_valid),
        .move_player (move_player), .move_idx (idx3), .move_ready (ready3), .move_ack (ack3),
        .illegal_move (ill3), .turn (turn3), .over (over3), .winner (winner3), .board_flat (board3)
    );

    nxn_board_engine #(.BOARD_N(5), .WIN_K(4)) dut5 (
        .clk (clk), .reset_n (reset_n), .new_game (new_game), .move_valid (move_valid),
        .move_player (move_player), .move_idx (idx5), .move_ready (ready5), .move_ack (ack5),
        .illegal_move (ill5), .turn (turn5), .over (over5), .winner (winner5), .board_flat (board5)
    );

    assign ready_m  = sel ? ready5  : ready3;
    assign ack_m    = sel ? ack5    : ack3;
    assign ill_m    = sel ? ill5    : ill3;
    assign turn_m   = sel ? turn5   : turn3;
    assign over_m   = sel ? over5   : over3;
    assign winner_m = sel ? winner5 : winner3;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every observed event must match the head of the scoreboard queue.
    always @(negedge clk) begin
        int   obs;
        exp_t e;
        cycle_cnt++;
        obs = K_NONE;
        if (ack_m === 1'b1)                        obs = K_ACK;
        else if (ill_m === 1'b1)                   obs = K_ILL;
        else if (over_m === 1'b1 && over_q == 1'b0) obs = K_OVER;
        if (obs != K_NONE) begin
            e.kind   = K_NONE;
            e.winner = 2'b00;
            if (sb.size() > 0) e = sb.pop_front();
            checkOutput("event_kind", 64'(obs), 64'(e.kind));
            if (obs == K_ACK) last_ack = cycle_cnt;
            if (obs == K_OVER && e.kind == K_OVER) begin
                checkOutput("winner", 64'(winner_m), 64'(e.winner));
                checkOutput("over_latency", 64'(cycle_cnt - last_ack), 64'd5);
            end
        end
        over_q = (over_m === 1'b1);
    end

    task automatic waitReady(input int exp_n);
        int n;
        n = 1;
        while (ready_m !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (ready_m !== 1'b1) checkOutput("ready_timeout", 64'(ready_m), 64'd1);
        else if (exp_n > 0)   checkOutput("ready_latency", 64'(n), 64'(exp_n));
    endtask

    task automatic waitOver();
        int n;
        n = 0;
        while (over_m !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (over_m !== 1'b1) checkOutput("over_timeout", 64'(over_m), 64'd1);
    endtask

    task automatic applyStimulus(input bit p, input int idx, input int kind, input int lat,
                                 input bit fin, input logic [1:0] wcode);
        exp_t e;
        waitReady(0);
        e.kind   = kind;
        e.winner = 2'b00;
        sb.push_back(e);
        if (fin) begin
            e.kind   = K_OVER;
            e.winner = wcode;
            sb.push_back(e);
        end
        move_player = p;
        move_valid  = 1'b1;
        idx3        = 4'(idx);
        idx5        = 5'(idx);
        @(negedge clk);
        move_valid = 1'b0;
        if (lat > 0) waitReady(lat);
    endtask

    task automatic pulseNewGame();
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset_n     = 1'b0;
        new_game    = 1'b0;
        move_valid  = 1'b0;
        move_player = 1'b0;
        idx3        = '0;
        idx5        = '0;
        sel         = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        checkOutput("rst_ready",  64'(ready3),  64'd1);
        checkOutput("rst_board",  64'(board3),  64'd0);
        checkOutput("rst_turn",   64'(turn3),   64'd0);
        checkOutput("rst_over",   64'(over3),   64'd0);
        checkOutput("rst_winner", 64'(winner3), 64'd0);

        // Occupied cell, out-of-range index, then wrong player.
        applyStimulus(1'b0, 0, K_ACK, 6, 1'b0, 2'b00);
        applyStimulus(1'b1, 0, K_ILL, 1, 1'b0, 2'b00);
        checkOutput("occ_board", 64'(board3), 64'h1);
        checkOutput("occ_turn",  64'(turn3),  64'd1);
        applyStimulus(1'b1, 9, K_ILL, 1, 1'b0, 2'b00);
        applyStimulus(1'b0, 4, K_ILL, 1, 1'b0, 2'b00);
        checkOutput("ill_board", 64'(board3), 64'h1);
        checkOutput("ill_turn",  64'(turn3),  64'd1);

        // Top-row win for P1, then a move attempt while DONE must be ignored.
        pulseNewGame();
        checkOutput("ng_board", 64'(board3), 64'd0);
        applyStimulus(1'b0, 0, K_ACK, 6, 1'b0, 2'b00);
        applyStimulus(1'b1, 3, K_ACK, 6, 1'b0, 2'b00);
        applyStimulus(1'b0, 1, K_ACK, 6, 1'b0, 2'b00);
        applyStimulus(1'b1, 4, K_ACK, 6, 1'b0, 2'b00);
        applyStimulus(1'b0, 2, K_ACK, 0, 1'b1, 2'b01);
        waitOver();
        checkOutput("win_board",  64'(board3),  64'h295);
        checkOutput("win_winner", 64'(winner3), 64'd1);
        move_player = 1'b1;
        idx3        = 4'd5;
        move_valid  = 1'b1;
        @(negedge clk);
        move_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("done_ready", 64'(ready3), 64'd0);
        checkOutput("done_board", 64'(board3), 64'h295);

        // Full board with no line is a draw.
        pulseNewGame();
        applyStimulus(1'b0, 0, K_ACK, 6, 1'b0, 2'b00);
        applyStimulus(1'b1, 1, K_ACK, 6, 1'b0, 2'b00);
        applyStimulus(1'b0, 2, K_ACK, 6, 1'b0, 2'b00);
        applyStimulus(1'b1, 4, K_ACK, 6, 1'b0, 2'b00);
        applyStimulus(1'b0, 3, K_ACK, 6, 1'b0, 2'b00);
        applyStimulus(1'b1, 5, K_ACK, 6, 1'b0, 2'b00);
        applyStimulus(1'b0, 7, K_ACK, 6, 1'b0, 2'b00);
        applyStimulus(1'b1, 6, K_ACK, 6, 1'b0, 2'b00);
        applyStimulus(1'b0, 8, K_ACK, 0, 1'b1, 2'b11);
        waitOver();
        checkOutput("draw_board",  64'(board3),  64'h16A59);
        checkOutput("draw_winner", 64'(winner3), 64'd3);

        // new_game during SCAN2 together with a move request.
        pulseNewGame();
        applyStimulus(1'b0, 4, K_ACK, 0, 1'b0, 2'b00);
        repeat (2) @(negedge clk);
        new_game    = 1'b1;
        move_valid  = 1'b1;
        move_player = 1'b1;
        idx3        = 4'd5;
        @(negedge clk);
        new_game   = 1'b0;
        move_valid = 1'b0;
        checkOutput("ng_scan_board", 64'(board3), 64'd0);
        checkOutput("ng_scan_turn",  64'(turn3),  64'd0);
        checkOutput("ng_scan_ready", 64'(ready3), 64'd1);
        repeat (8) @(negedge clk);

        // Reset during SCAN1 abandons the scan silently.
        applyStimulus(1'b0, 4, K_ACK, 0, 1'b0, 2'b00);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_scan_ready", 64'(ready3), 64'd1);
        checkOutput("rst_scan_board", 64'(board3), 64'd0);
        checkOutput("rst_scan_over",  64'(over3),  64'd0);
        repeat (8) @(negedge clk);
        checkOutput("rst_scan_over_late", 64'(over3), 64'd0);

        // 5x5, K=4: stones 3,4,5,6 must not win across the row wrap; anti-diagonal 3,7,11,15 wins.
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        sel     = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 4,  K_ACK, 6, 1'b0, 2'b00);
        applyStimulus(1'b1, 0,  K_ACK, 6, 1'b0, 2'b00);
        applyStimulus(1'b0, 5,  K_ACK, 6, 1'b0, 2'b00);
        applyStimulus(1'b1, 1,  K_ACK, 6, 1'b0, 2'b00);
        applyStimulus(1'b0, 6,  K_ACK, 6, 1'b0, 2'b00);
        applyStimulus(1'b1, 2,  K_ACK, 6, 1'b0, 2'b00);
        applyStimulus(1'b0, 3,  K_ACK, 6, 1'b0, 2'b00);
        checkOutput("n5_no_wrap_win", 64'(over5), 64'd0);
        applyStimulus(1'b1, 20, K_ACK, 6, 1'b0, 2'b00);
        applyStimulus(1'b0, 7,  K_ACK, 6, 1'b0, 2'b00);
        applyStimulus(1'b1, 21, K_ACK, 6, 1'b0, 2'b00);
        applyStimulus(1'b0, 11, K_ACK, 6, 1'b0, 2'b00);
        applyStimulus(1'b1, 24, K_ACK, 6, 1'b0, 2'b00);
        applyStimulus(1'b0, 15, K_ACK, 0, 1'b1, 2'b01);
        waitOver();
        checkOutput("n5_winner", 64'(winner5), 64'd1);

        repeat (4) @(negedge clk);
        checkOutput("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
